processing_unit: RTL and testbench

`processing_unit` is the NUM_PE-lane fixed-point compute datapath of the DNN accelerator. It holds a packed weight buffer filled from the 64-bit memory read stream and broadcasts one weight per cycle to all lanes. Each lane runs a signed multiply-accumulate against its slice of the input vector from the vector generator. Results are saturated, optionally 2:1 max-pooled, and presented on a write port to the output buffer; the PU controller sequences it through `pe_ctrl`.

---
 rtl/processing_unit.sv | 209 ++++++++++++++++++++
 tb/tb_processing_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/processing_unit.sv
// processing_unit: NUM_PE-lane signed fixed-point MAC datapath with a packed
// weight buffer, per-lane saturation, optional 2:1 max-pooling of successive
// FLUSH results, and a valid/ready result write port.
module processing_unit #(
    parameter int OP_WIDTH  = 16,
    parameter int NUM_PE    = 4,
    parameter int FRAC_BITS = 8,
    parameter int WB_ADDR_W = 9,
    parameter int PE_CTRL_W = 30
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         buffer_read_data_valid,
    input  logic [63:0]                  read_data,
    input  logic                         wb_read_req,
    input  logic [WB_ADDR_W-1:0]         wb_read_addr,
    input  logic [PE_CTRL_W-1:0]         pe_ctrl,
    input  logic [NUM_PE*OP_WIDTH-1:0]   vecgen_wr_data,
    input  logic [NUM_PE-1:0]            vecgen_mask,
    input  logic [2:0]                   pool_cfg,
    output logic                         read_req,
    output logic [NUM_PE*OP_WIDTH-1:0]   write_data,
    output logic                         write_req,
    input  logic                         write_ready
);

    localparam int ACC_W    = 2*OP_WIDTH + 8;
    localparam int SHR_W    = ACC_W - FRAC_BITS;
    localparam int WB_DEPTH = 1 << WB_ADDR_W;
    localparam int WPB      = 64 / OP_WIDTH;
    localparam int VEC_W    = NUM_PE*OP_WIDTH;

    typedef enum logic [2:0] {
        OP_MUL      = 3'd0,
        OP_MAC      = 3'd1,
        OP_BIAS     = 3'd2,
        OP_MAX      = 3'd3,
        OP_LOAD     = 3'd4,
        OP_CLEAR    = 3'd5,
        OP_FLUSH    = 3'd6,
        OP_WB_RESET = 3'd7
    } op_e;

    // Saturate the arithmetically-shifted accumulator (top bits only) to OP_WIDTH.
    function automatic logic [OP_WIDTH-1:0] sat(input logic [SHR_W-1:0] v);
        logic [SHR_W-OP_WIDTH:0] top;
        top = v[SHR_W-1:OP_WIDTH-1];
        if ((&top) || (~|top))
            sat = v[OP_WIDTH-1:0];
        else if (v[SHR_W-1])
            sat = {1'b1, {(OP_WIDTH-1){1'b0}}};
        else
            sat = {1'b0, {(OP_WIDTH-1){1'b1}}};
    endfunction

    logic op_en;
    op_e  opc;
    assign op_en = pe_ctrl[0];
    assign opc   = op_e'(pe_ctrl[3:1]);

    // Control bits beyond the opcode and the reserved pool bits carry no meaning.
    logic unused_ctrl;
    assign unused_ctrl = ^{pe_ctrl[PE_CTRL_W-1:4], pool_cfg[2:1]};

    // Vector consumption is combinational and forced low while in reset.
    assign read_req = reset && op_en &&
                      (opc == OP_MUL || opc == OP_MAC || opc == OP_MAX || opc == OP_LOAD);

    // ------------------------------------------------------------------
    // Weight buffer
    // ------------------------------------------------------------------
    logic [OP_WIDTH-1:0]        wb_mem [WB_DEPTH];
    logic [WB_ADDR_W-1:0]       wp_q, wp_d;
    logic signed [OP_WIDTH-1:0] weight_q;

    // Write pointer advances one beat's worth of entries; WB_RESET rewinds it.
    always_comb begin
        wp_d = wp_q;
        if (buffer_read_data_valid)
            wp_d = wp_q + WB_ADDR_W'(WPB);
        if (op_en && opc == OP_WB_RESET)
            wp_d = '0;
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wp_q <= '0;
        else        wp_q <= wp_d;
    end

    // Each valid beat writes all packed entries at consecutive (wrapping) addresses.
    always_ff @(posedge clk) begin
        if (buffer_read_data_valid) begin
            for (int k = 0; k < WPB; k++)
                wb_mem[wp_q + WB_ADDR_W'(k)] <= read_data[k*OP_WIDTH +: OP_WIDTH];
        end
    end

    // Registered read; a same-edge write to the same entry yields the old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          weight_q <= '0;
        else if (wb_read_req) weight_q <= wb_mem[wb_read_addr];
    end

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    logic [VEC_W-1:0] res_vec;
    logic [VEC_W-1:0] pool_vec;
    logic [VEC_W-1:0] hold_q, hold_d;

    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
        logic signed [OP_WIDTH-1:0]   a_s;
        logic signed [2*OP_WIDTH-1:0] prod;
        logic signed [ACC_W-1:0]      prod_ext, a_ext, w_ext;
        logic signed [ACC_W-1:0]      acc_q, acc_d;
        logic signed [OP_WIDTH-1:0]   hold_s, res_s;

        assign a_s      = vecgen_wr_data[gi*OP_WIDTH +: OP_WIDTH];
        assign prod     = a_s * weight_q;
        assign prod_ext = {{(ACC_W-2*OP_WIDTH){prod[2*OP_WIDTH-1]}}, prod};
        assign a_ext    = {{(ACC_W-OP_WIDTH-FRAC_BITS){a_s[OP_WIDTH-1]}}, a_s, {FRAC_BITS{1'b0}}};
        assign w_ext    = {{(ACC_W-OP_WIDTH-FRAC_BITS){weight_q[OP_WIDTH-1]}}, weight_q, {FRAC_BITS{1'b0}}};

        // Accumulator update; masked lanes hold except for CLEAR.
        always_comb begin
            acc_d = acc_q;
            if (op_en) begin
                case (opc)
                    OP_MUL:   if (vecgen_mask[gi]) acc_d = prod_ext;
                    OP_MAC:   if (vecgen_mask[gi]) acc_d = acc_q + prod_ext;
                    OP_BIAS:  if (vecgen_mask[gi]) acc_d = acc_q + w_ext;
                    OP_MAX:   if (vecgen_mask[gi] && (a_ext > acc_q)) acc_d = a_ext;
                    OP_LOAD:  if (vecgen_mask[gi]) acc_d = a_ext;
                    OP_CLEAR: acc_d = '0;
                    default:  ;
                endcase
            end
        end

        // Accumulator register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) acc_q <= '0;
            else        acc_q <= acc_d;
        end

        assign res_vec[gi*OP_WIDTH +: OP_WIDTH] = sat(acc_q[ACC_W-1:FRAC_BITS]);

        assign hold_s = hold_q[gi*OP_WIDTH +: OP_WIDTH];
        assign res_s  = res_vec[gi*OP_WIDTH +: OP_WIDTH];
        assign pool_vec[gi*OP_WIDTH +: OP_WIDTH] = (hold_s > res_s) ? hold_s : res_s;
    end

    // ------------------------------------------------------------------
    // Pooling and output port
    // ------------------------------------------------------------------
    logic             flush, pool_en, emit;
    logic             parity_q, parity_d;
    logic [VEC_W-1:0] out_val;
    logic [VEC_W-1:0] wdata_q, wdata_d;
    logic             wreq_q, wreq_d;

    assign flush   = op_en && (opc == OP_FLUSH);
    assign pool_en = pool_cfg[0];
    assign emit    = flush && (!pool_en || parity_q);
    assign out_val = pool_en ? pool_vec : res_vec;

    // Parity tracks odd/even FLUSH while pooling; the first of a pair is held.
    always_comb begin
        parity_d = 1'b0;
        hold_d   = hold_q;
        if (pool_en) begin
            parity_d = flush ? ~parity_q : parity_q;
            if (flush && !parity_q)
                hold_d = res_vec;
        end
    end

    // A new result always wins; otherwise an accepted transfer drops write_req.
    always_comb begin
        wdata_d = wdata_q;
        wreq_d  = wreq_q;
        if (emit) begin
            wdata_d = out_val;
            wreq_d  = 1'b1;
        end else if (write_ready) begin
            wreq_d  = 1'b0;
        end
    end

    // Pool and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
            hold_q   <= '0;
            wdata_q  <= '0;
            wreq_q   <= 1'b0;
        end else begin
            parity_q <= parity_d;
            hold_q   <= hold_d;
            wdata_q  <= wdata_d;
            wreq_q   <= wreq_d;
        end
    end

    assign write_data = wdata_q;
    assign write_req  = wreq_q;

endmodule

// File: tb/tb_processing_unit.sv
// Scoreboard bench for processing_unit: stimulus pushes expected result vectors,
// a negedge monitor pops and compares on every accepted write transfer.
module tb_processing_unit;

    localparam int OPW  = 16;
    localparam int NPE  = 4;
    localparam int FRAC = 8;
    localparam int WBA  = 9;
    localparam int PCW  = 30;

    localparam logic [2:0] MUL = 3'd0, MAC = 3'd1, BIAS = 3'd2, MAXO = 3'd3,
                           LOAD = 3'd4, CLR = 3'd5, FLUSH = 3'd6, WBRST = 3'd7;

    logic               clk;
    logic               reset;
    logic               buffer_read_data_valid;
    logic [63:0]        read_data;
    logic               wb_read_req;
    logic [WBA-1:0]     wb_read_addr;
    logic [PCW-1:0]     pe_ctrl;
    logic [NPE*OPW-1:0] vecgen_wr_data;
    logic [NPE-1:0]     vecgen_mask;
    logic [2:0]         pool_cfg;
    logic               read_req;
    logic [NPE*OPW-1:0] write_data;
    logic               write_req;
    logic               write_ready;

    processing_unit #(
        .OP_WIDTH(OPW), .NUM_PE(NPE), .FRAC_BITS(FRAC),
        .WB_ADDR_W(WBA), .PE_CTRL_W(PCW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buffer_read_data_valid(buffer_read_data_valid),
        .read_data(read_data),
        .wb_read_req(wb_read_req),
        .wb_read_addr(wb_read_addr),
        .pe_ctrl(pe_ctrl),
        .vecgen_wr_data(vecgen_wr_data),
        .vecgen_mask(vecgen_mask),
        .pool_cfg(pool_cfg),
        .read_req(read_req),
        .write_data(write_data),
        .write_req(write_req),
        .write_ready(write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    int n_cmp  = 0;
    int n_fail = 0;
    int rr_cnt = 0;

    function automatic logic [63:0] v4(input logic [15:0] l3, input logic [15:0] l2,
                                       input logic [15:0] l1, input logic [15:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] all4(input logic [15:0] x);
        return {x, x, x, x};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every accepted transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (reset && write_req && write_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got %h required no transfer", write_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_data", write_data, mon_exp);
            end
        end
    end

    task automatic op(input logic [2:0] opc, input logic [63:0] a, input logic [3:0] mask,
                      input logic rd, input logic [WBA-1:0] addr, input logic en);
        pe_ctrl        = {{(PCW-4){1'b0}}, opc, en};
        vecgen_wr_data = a;
        vecgen_mask    = mask;
        wb_read_req    = rd;
        wb_read_addr   = addr;
        #1;
        if (read_req) rr_cnt++;
        @(posedge clk);
        #1;
        pe_ctrl     = '0;
        wb_read_req = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] opc, input logic [63:0] a, input logic [3:0] mask);
        op(opc, a, mask, 1'b0, '0, 1'b1);
    endtask

    task automatic flush(input logic push, input logic [63:0] e);
        if (push) exp_q.push_back(e);
        op(FLUSH, 64'd0, 4'hF, 1'b0, '0, 1'b1);
    endtask

    task automatic beat(input logic [63:0] d);
        buffer_read_data_valid = 1'b1;
        read_data              = d;
        @(posedge clk);
        #1;
        buffer_read_data_valid = 1'b0;
    endtask

    task automatic rd_check(input logic [WBA-1:0] addr, input logic [15:0] val);
        op(CLR, 64'd0, 4'hF, 1'b1, addr, 1'b1);
        do_op(BIAS, 64'd0, 4'hF);
        flush(1'b1, all4(val));
    endtask

    int wait_cnt;

    initial begin
        reset = 1'b0;
        buffer_read_data_valid = 1'b0;
        read_data = '0;
        wb_read_req = 1'b0;
        wb_read_addr = '0;
        vecgen_wr_data = all4(16'h0100);
        vecgen_mask = 4'hF;
        pool_cfg = 3'b000;
        write_ready = 1'b1;
        pe_ctrl = {{(PCW-4){1'b0}}, MAC, 1'b1};

        // Reset state with a MAC presented.
        repeat (2) @(posedge clk);
        #1;
        check("rst_write_req", {63'd0, write_req}, 64'd0);
        check("rst_write_data", write_data, 64'd0);
        check("rst_read_req", {63'd0, read_req}, 64'd0);
        pe_ctrl = '0;
        reset = 1'b1;

        // Leave a result pending, then reset mid-MAC.
        write_ready = 1'b0;
        do_op(LOAD, all4(16'h0100), 4'hF);
        flush(1'b0, 64'd0);
        check("pending_write_req", {63'd0, write_req}, 64'd1);
        check("pending_write_data", write_data, all4(16'h0100));
        pe_ctrl = {{(PCW-4){1'b0}}, MAC, 1'b1};
        vecgen_wr_data = all4(16'h0100);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_write_req", {63'd0, write_req}, 64'd0);
        check("midrst_write_data", write_data, 64'd0);
        check("midrst_read_req", {63'd0, read_req}, 64'd0);
        @(posedge clk);
        #1;
        pe_ctrl = '0;
        reset = 1'b1;
        write_ready = 1'b1;
        flush(1'b1, 64'd0);
        do_op(BIAS, 64'd0, 4'hF);
        flush(1'b1, 64'd0);

        // Weight loading and read-back through BIAS.
        beat(64'h0004_0003_0002_0001);
        beat(v4(16'h0000, 16'h8100, 16'h7F00, 16'h0200));
        for (int k = 0; k < 4; k++)
            rd_check(WBA'(k), 16'(k + 1));

        // MUL then MAC: 1.5 * 2.0 twice = 6.0.
        rr_cnt = 0;
        op(MUL, 64'd0, 4'h0, 1'b1, 9'd4, 1'b0);
        do_op(MUL, all4(16'h0180), 4'hF);
        do_op(MAC, all4(16'h0180), 4'hF);
        flush(1'b1, all4(16'h0600));
        check("read_req_cycles", 64'(rr_cnt), 64'd2);

        // Masked MAC.
        do_op(MUL, all4(16'h0180), 4'hF);
        do_op(MAC, all4(16'h0180), 4'b0101);
        flush(1'b1, v4(16'h0300, 16'h0600, 16'h0300, 16'h0600));

        // MAX against mixed-sign inputs.
        do_op(LOAD, all4(16'h0100), 4'hF);
        do_op(MAXO, v4(16'h0200, 16'hFF00, 16'h0100, 16'h0050), 4'hF);
        flush(1'b1, v4(16'h0200, 16'h0100, 16'h0100, 16'h0100));

        // Saturation, positive and negative.
        op(LOAD, all4(16'h7F00), 4'hF, 1'b1, 9'd5, 1'b1);
        do_op(BIAS, 64'd0, 4'hF);
        flush(1'b1, all4(16'h7FFF));
        op(LOAD, all4(16'h8100), 4'hF, 1'b1, 9'd6, 1'b1);
        do_op(BIAS, 64'd0, 4'hF);
        flush(1'b1, all4(16'h8000));

        // Pooling pair, with the sink stalling for 3 cycles.
        pool_cfg = 3'b001;
        do_op(LOAD, v4(16'h0100, 16'hFF00, 16'h0100, 16'h0100), 4'hF);
        flush(1'b0, 64'd0);
        do_op(LOAD, v4(16'h0300, 16'hFF00, 16'h0300, 16'h0300), 4'hF);
        write_ready = 1'b0;
        flush(1'b1, v4(16'h0300, 16'hFF00, 16'h0300, 16'h0300));
        for (int c = 0; c < 3; c++) begin
            check("stall_write_req", {63'd0, write_req}, 64'd1);
            check("stall_write_data", write_data, v4(16'h0300, 16'hFF00, 16'h0300, 16'h0300));
            @(posedge clk);
            #1;
        end
        write_ready = 1'b1;
        @(posedge clk);
        #1;
        pool_cfg = 3'b000;

        // Pointer wrap: 129 beats overwrite entries 0..3 only.
        do_op(WBRST, 64'd0, 4'h0);
        for (int b = 0; b < 128; b++)
            beat(all4(16'h0011));
        beat(v4(16'h0005, 16'h0006, 16'h0007, 16'h0009));
        rd_check(9'd0, 16'h0009);
        rd_check(9'd1, 16'h0007);
        rd_check(9'd4, 16'h0011);
        rd_check(9'd511, 16'h0011);

        // Drain the scoreboard with a bounded wait.
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 50) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d outstanding results required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
